// File: rtl/img_mem_reader_scaled.sv
// Frame-buffer reader: VGA scan position -> BRAM address, RGB444 VGA colour with ROI border, RGB888 detector stream.
// Latency: addr is combinational; every other output lags x_pixel/y_pixel by MEM_LAT+1 clocks.
// Backpressure: none; free-running pixel pipeline accepting one scan position per clock.
module img_mem_reader_scaled #(
    parameter int          IMG_W     = 320,
    parameter int          IMG_H     = 240,
    parameter int          ADDR_W    = 17,
    parameter int          MEM_LAT   = 1,
    parameter logic [11:0] ROI_COLOR = 12'hF00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              DE,
    input  logic [9:0]        x_pixel,
    input  logic [9:0]        y_pixel,
    input  logic              scale_sel,
    input  logic              roi_en,
    input  logic [9:0]        roi_x0,
    input  logic [9:0]        roi_x1,
    input  logic [9:0]        roi_y0,
    input  logic [9:0]        roi_y1,
    output logic [ADDR_W-1:0] addr,
    input  logic [15:0]       imgData,
    output logic [3:0]        r_port,
    output logic [3:0]        g_port,
    output logic [3:0]        b_port,
    output logic              pixel_valid,
    output logic [9:0]        pixel_x,
    output logic [9:0]        pixel_y,
    output logic [7:0]        pixel_r8,
    output logic [7:0]        pixel_g8,
    output logic [7:0]        pixel_b8,
    output logic              line_start,
    output logic              frame_start,
    output logic              frame_end
);

    localparam logic [31:0] IMG_W_L = 32'(IMG_W);
    localparam logic [31:0] IMG_H_L = 32'(IMG_H);

    // Per-pixel side information carried alongside the BRAM read
    typedef struct packed {
        logic       win;
        logic       fv;
        logic       roi;
        logic [9:0] ix;
        logic [9:0] iy;
    } tap_t;

    logic [1:0]  rst_sync_q;
    logic        rst_ok;
    logic        mode_q, mode_d;
    logic [9:0]  ix, iy;
    logic        in_win, first_vis, roi_hit;
    logic [31:0] lin_addr;
    tap_t        tap_in, tap_out;
    tap_t        pipe_q [MEM_LAT];

    logic        valid_q, valid_d;
    logic [9:0]  px_q, px_d, py_q, py_d;
    logic [23:0] rgb_q, rgb_d;
    logic [11:0] vga_q, vga_d;
    logic        ls_q, ls_d, fs_q, fs_d, fe_q, fe_d;

    // Reset synchroniser: asserts immediately, releases on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_ok = rst_sync_q[1];

    // Display mode only switches at screen origin so a frame is never mixed
    always_comb begin
        mode_d = mode_q;
        if (x_pixel == 10'd0 && y_pixel == 10'd0) mode_d = scale_sel;
    end

    // Mode register
    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) mode_q <= 1'b0;
        else         mode_q <= mode_d;
    end

    assign ix = mode_q ? {1'b0, x_pixel[9:1]} : x_pixel;
    assign iy = mode_q ? {1'b0, y_pixel[9:1]} : y_pixel;

    // Gating with rst_ok keeps addr at zero while the block is held in reset
    assign in_win    = rst_ok && DE && ({22'd0, ix} < IMG_W_L) && ({22'd0, iy} < IMG_H_L);
    assign lin_addr  = {22'd0, iy} * IMG_W_L + {22'd0, ix};
    assign addr      = in_win ? lin_addr[ADDR_W-1:0] : '0;
    // In 2x mode only the top-left screen copy of each image pixel goes to the stream
    assign first_vis = in_win && (!mode_q || (!x_pixel[0] && !y_pixel[0]));
    assign roi_hit   = roi_en && in_win && (roi_x0 <= roi_x1) && (roi_y0 <= roi_y1)
                    && (ix >= roi_x0) && (ix <= roi_x1) && (iy >= roi_y0) && (iy <= roi_y1)
                    && (ix == roi_x0 || ix == roi_x1 || iy == roi_y0 || iy == roi_y1);

    assign tap_in  = '{win: in_win, fv: first_vis, roi: roi_hit, ix: ix, iy: iy};
    assign tap_out = pipe_q[MEM_LAT-1];

    // Delay line matching the frame-buffer read latency
    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) begin
            for (int i = 0; i < MEM_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= tap_in;
            for (int i = 1; i < MEM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Output stage: combine delayed side information with the returned pixel
    always_comb begin
        vga_d = 12'h000;
        if (tap_out.roi)      vga_d = ROI_COLOR;
        else if (tap_out.win) vga_d = {imgData[15:12], imgData[10:7], imgData[4:1]};
        valid_d = tap_out.fv;
        px_d    = px_q;
        py_d    = py_q;
        rgb_d   = 24'd0;
        if (tap_out.fv) begin
            px_d  = tap_out.ix;
            py_d  = tap_out.iy;
            rgb_d = {imgData[15:11], imgData[15:13],
                     imgData[10:5],  imgData[10:9],
                     imgData[4:0],   imgData[4:2]};
        end
        ls_d = tap_out.fv && (tap_out.ix == 10'd0);
        fs_d = ls_d && (tap_out.iy == 10'd0);
        fe_d = tap_out.fv && ({22'd0, tap_out.ix} == IMG_W_L - 32'd1)
                          && ({22'd0, tap_out.iy} == IMG_H_L - 32'd1);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_ok) begin
        if (!rst_ok) begin
            valid_q <= 1'b0;
            px_q    <= 10'd0;
            py_q    <= 10'd0;
            rgb_q   <= 24'd0;
            vga_q   <= 12'd0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rgb_q   <= rgb_d;
            vga_q   <= vga_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fe_q    <= fe_d;
        end
    end

    assign pixel_valid = valid_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign pixel_r8    = rgb_q[23:16];
    assign pixel_g8    = rgb_q[15:8];
    assign pixel_b8    = rgb_q[7:0];
    assign r_port      = vga_q[11:8];
    assign g_port      = vga_q[7:4];
    assign b_port      = vga_q[3:0];
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;

endmodule

// File: tb/tb_img_mem_reader_scaled.sv
// Testbench for img_mem_reader_scaled on a reduced 24x16 image and 56x36 screen.
// Latency: expects outputs MEM_LAT+1 clocks after each driven scan position.
// Backpressure: none; scan positions are driven one per clock.
module tb_img_mem_reader_scaled;

    localparam int IMG_W   = 24;
    localparam int IMG_H   = 16;
    localparam int ADDR_W  = 9;
    localparam int MEM_LAT = 3;
    localparam int L       = MEM_LAT + 1;
    localparam int SCR_W   = 56;
    localparam int SCR_H   = 36;
    localparam int ACT_W   = 48;
    localparam int ACT_H   = 32;
    localparam logic [11:0] ROI_C = 12'hF00;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              DE;
    logic [9:0]        x_pixel, y_pixel;
    logic              scale_sel, roi_en;
    logic [9:0]        roi_x0, roi_x1, roi_y0, roi_y1;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       imgData;
    logic [3:0]        r_port, g_port, b_port;
    logic              pixel_valid;
    logic [9:0]        pixel_x, pixel_y;
    logic [7:0]        pixel_r8, pixel_g8, pixel_b8;
    logic              line_start, frame_start, frame_end;

    img_mem_reader_scaled #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .ROI_COLOR(ROI_C)
    ) dut (
        .clk(clk), .reset_n(reset_n), .DE(DE), .x_pixel(x_pixel), .y_pixel(y_pixel),
        .scale_sel(scale_sel), .roi_en(roi_en), .roi_x0(roi_x0), .roi_x1(roi_x1),
        .roi_y0(roi_y0), .roi_y1(roi_y1), .addr(addr), .imgData(imgData),
        .r_port(r_port), .g_port(g_port), .b_port(b_port), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_r8(pixel_r8), .pixel_g8(pixel_g8),
        .pixel_b8(pixel_b8), .line_start(line_start), .frame_start(frame_start),
        .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    // Frame-buffer model with MEM_LAT clocks of read latency
    logic [15:0]       mem   [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] ahist [0:MEM_LAT-1];
    always @(posedge clk) begin
        ahist[0] <= addr;
        for (int i = 1; i < MEM_LAT; i++) ahist[i] <= ahist[i-1];
    end
    assign imgData = mem[ahist[MEM_LAT-1]];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cyc_00 = -1000;
    int cur_f = -1;
    int m_mode = 0;
    int last_px = 0, last_py = 0;
    logic [59:0] expq[$];
    int dut_v, dut_ls, dut_fs, dut_fe, mdl_v, mdl_ls, mdl_fs, mdl_fe;

    function automatic logic [59:0] observed();
        return {pixel_valid, pixel_x, pixel_y, pixel_r8, pixel_g8, pixel_b8,
                r_port, g_port, b_port, line_start, frame_start, frame_end};
    endfunction

    function automatic logic [59:0] idle_entry();
        return {1'b0, 10'(last_px), 10'(last_py), 39'd0};
    endfunction

    // One pixel clock: check outputs due now, drive the next scan position, predict its results
    task automatic step(input int x, input int y, input bit de);
        logic [59:0] obs, exp;
        int ix, iy, a, r5, g6, b5, vga, r8, g8, b8;
        bit win, fv, hit, ls, fs, fe;
        logic [15:0] d;
        @(posedge clk);
        #1;
        obs = observed();
        exp = expq.pop_front();
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL out cyc=%0d observed=%h expected=%h", cyc, obs, exp);
        end
        dut_v += int'(pixel_valid); dut_ls += int'(line_start);
        dut_fs += int'(frame_start); dut_fe += int'(frame_end);
        mdl_v += int'(exp[59]); mdl_ls += int'(exp[2]); mdl_fs += int'(exp[1]); mdl_fe += int'(exp[0]);
        if (frame_start) begin
            checks++;
            assert (cyc - cyc_00 === L) else begin
                errors++;
                $error("FAIL fs_latency observed=%0d expected=%0d", cyc - cyc_00, L);
            end
        end
        if (cur_f == 0 && frame_start) begin
            checks++;
            assert ({pixel_r8, pixel_g8, pixel_b8, r_port, g_port, b_port} === 36'hFF00FF_F0F) else begin
                errors++;
                $error("FAIL f81f observed=%h expected=%h",
                       {pixel_r8, pixel_g8, pixel_b8, r_port, g_port, b_port}, 36'hFF00FF_F0F);
            end
        end
        if (cur_f == 0 && pixel_valid && ((pixel_x == 10 && pixel_y == 12) || (pixel_x == 15 && pixel_y == 15))) begin
            checks++;
            assert ({r_port, g_port, b_port} === ROI_C) else begin
                errors++;
                $error("FAIL roi_border observed=%h expected=%h", {r_port, g_port, b_port}, ROI_C);
            end
        end
        if (cur_f == 0 && pixel_valid && pixel_x == 15 && pixel_y == 12) begin
            d = mem[12*IMG_W+15];
            checks++;
            assert ({r_port, g_port, b_port} === {d[15:12], d[10:7], d[4:1]}) else begin
                errors++;
                $error("FAIL roi_inside observed=%h expected=%h", {r_port, g_port, b_port}, {d[15:12], d[10:7], d[4:1]});
            end
        end
        x_pixel = 10'(x);
        y_pixel = 10'(y);
        DE      = de;
        #1;
        ix  = (m_mode != 0) ? x / 2 : x;
        iy  = (m_mode != 0) ? y / 2 : y;
        win = de && ix < IMG_W && iy < IMG_H;
        a   = win ? (iy * IMG_W + ix) % (1 << ADDR_W) : 0;
        fv  = win && (m_mode == 0 || (x % 2 == 0 && y % 2 == 0));
        hit = roi_en && win && roi_x0 <= roi_x1 && roi_y0 <= roi_y1
           && ix >= int'(roi_x0) && ix <= int'(roi_x1) && iy >= int'(roi_y0) && iy <= int'(roi_y1)
           && (ix == int'(roi_x0) || ix == int'(roi_x1) || iy == int'(roi_y0) || iy == int'(roi_y1));
        d   = mem[a];
        r5  = int'(d) / 2048;
        g6  = (int'(d) / 32) % 64;
        b5  = int'(d) % 32;
        vga = hit ? int'(ROI_C) : (win ? (r5 / 2) * 256 + (g6 / 4) * 16 + b5 / 2 : 0);
        r8  = fv ? r5 * 8 + r5 / 4 : 0;
        g8  = fv ? g6 * 4 + g6 / 16 : 0;
        b8  = fv ? b5 * 8 + b5 / 4 : 0;
        if (fv) begin last_px = ix; last_py = iy; end
        ls  = fv && ix == 0;
        fs  = ls && iy == 0;
        fe  = fv && ix == IMG_W - 1 && iy == IMG_H - 1;
        expq.push_back({fv, 10'(last_px), 10'(last_py), 8'(r8), 8'(g8), 8'(b8), 12'(vga), ls, fs, fe});
        checks++;
        assert (addr === ADDR_W'(a)) else begin
            errors++;
            $error("FAIL addr x=%0d y=%0d observed=%0d expected=%0d", x, y, addr, a);
        end
        if (x == 0 && y == 0) begin
            m_mode = int'(scale_sel);
            cyc_00 = cyc;
        end
        cyc++;
    endtask

    // Mid-frame asynchronous reset; model restarts from its reset state
    task automatic do_reset();
        #1 reset_n = 1'b0;
        #1;
        checks++;
        assert ({observed(), addr} === '0) else begin
            errors++;
            $error("FAIL async_reset observed=%h addr=%0d expected all zero", observed(), addr);
        end
        expq.delete();
        m_mode = 0; last_px = 0; last_py = 0; cyc_00 = -1000;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int i = 0; i < L; i++) expq.push_back(idle_entry());
    endtask

    initial begin
        int x;
        bit sc, drops, clean, de;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'($urandom);
        mem[0] = 16'hF81F;
        for (int i = 0; i < MEM_LAT; i++) ahist[i] = '0;
        reset_n = 1'b0; DE = 1'b0; x_pixel = 10'd50; y_pixel = 10'd34;
        scale_sel = 1'b0; roi_en = 1'b0;
        roi_x0 = 10'd0; roi_x1 = 10'd0; roi_y0 = 10'd0; roi_y1 = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert ({observed(), addr} === '0) else begin
            errors++;
            $error("FAIL reset_state observed=%h addr=%0d expected all zero", observed(), addr);
        end
        reset_n = 1'b1;
        for (int i = 0; i < L; i++) expq.push_back(idle_entry());
        for (int i = 0; i < 8; i++) step(50, 34, 1'b0);

        for (int f = 0; f < 8; f++) begin
            cur_f = f;
            dut_v = 0; dut_ls = 0; dut_fs = 0; dut_fe = 0;
            mdl_v = 0; mdl_ls = 0; mdl_fs = 0; mdl_fe = 0;
            sc    = (f == 0) ? 1'b0 : (f == 1) ? 1'b1 : 1'($urandom);
            drops = (f >= 4) && (f % 2 == 0);
            clean = !drops && (f != 5);
            if (f == 0) begin
                roi_en = 1'b1; roi_x0 = 10'd10; roi_x1 = 10'd20; roi_y0 = 10'd10; roi_y1 = 10'd15;
            end else if (f == 1) begin
                roi_en = 1'b1; roi_x0 = 10'd20; roi_x1 = 10'd10; roi_y0 = 10'd10; roi_y1 = 10'd15;
            end else begin
                roi_en = ($urandom % 4) != 0;
                roi_x0 = 10'($urandom % 30); roi_x1 = 10'($urandom % 30);
                roi_y0 = 10'($urandom % 20); roi_y1 = 10'($urandom % 20);
            end
            for (int y = 0; y < SCR_H; y++) begin
                scale_sel = (y >= 10) ? !sc : sc;
                x = 0;
                while (x < SCR_W) begin
                    de = (x < ACT_W) && (y < ACT_H) && !(drops && ($urandom % 16) == 0);
                    step(x, y, de);
                    if (f == 0 && x == 5 && y == 2) begin
                        checks++;
                        assert (addr === ADDR_W'(53)) else begin
                            errors++;
                            $error("FAIL addr_5_2 observed=%0d expected=53", addr);
                        end
                    end
                    if (f == 1 && x == 7 && y == 9) begin
                        checks++;
                        assert (addr === ADDR_W'(99)) else begin
                            errors++;
                            $error("FAIL addr_7_9 observed=%0d expected=99", addr);
                        end
                    end
                    if (f == 5 && y == 5 && x == 20) begin
                        do_reset();
                        x = 44;
                    end else begin
                        x++;
                    end
                end
            end
            checks++;
            assert (dut_v === (clean ? IMG_W * IMG_H : mdl_v)) else begin
                errors++;
                $error("FAIL frame%0d valid_count observed=%0d expected=%0d", f, dut_v, clean ? IMG_W * IMG_H : mdl_v);
            end
            checks++;
            assert ({dut_ls, dut_fs, dut_fe} === (clean ? {IMG_H, 1, 1} : {mdl_ls, mdl_fs, mdl_fe})) else begin
                errors++;
                $error("FAIL frame%0d pulse_counts observed=%0d/%0d/%0d model=%0d/%0d/%0d",
                       f, dut_ls, dut_fs, dut_fe, mdl_ls, mdl_fs, mdl_fe);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/img_mem_reader_scaled.md
Name: img_mem_reader_scaled

Overview:
Parametrised frame-buffer reader that converts VGA scan coordinates into frame-buffer addresses, compensates a configurable memory read latency, and emits both a 4-bit-per-channel VGA colour and an aligned RGB888 pixel stream for the colour detector. It supports 1:1 and 2x pixel-replicated display modes and draws a ROI rectangle on the VGA path only. It sits between the VGA timing generator plus frame-buffer BRAM and the color detector/VGA pins.

Parameters:
IMG_W, 320, image width in pixels
IMG_H, 240, image height in lines
ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
MEM_LAT, 1, frame-buffer read latency in clocks (legal 1..4)
ROI_COLOR, 12'hF00, RGB444 colour of the ROI border

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
DE  in  1  display enable from VGA timing
x_pixel  in  10  screen x
y_pixel  in  10  screen y
scale_sel  in  1  0 = 1:1, 1 = 2x upscale
roi_en  in  1  enable ROI border overlay
roi_x0, roi_x1  in  10 each  ROI left/right, image coordinates, inclusive
roi_y0, roi_y1  in  10 each  ROI top/bottom, image coordinates, inclusive
addr  out  ADDR_W  frame-buffer read address
imgData  in  16  RGB565 read data, valid MEM_LAT clocks after addr
r_port, g_port, b_port  out  4 each  VGA colour
pixel_valid  out  1  stream pixel valid
pixel_x, pixel_y  out  10 each  image coordinates of stream pixel
pixel_r8, pixel_g8, pixel_b8  out  8 each  RGB888 stream colour
line_start  out  1  pulse with first pixel of each image line
frame_start  out  1  pulse with image pixel (0,0)
frame_end  out  1  pulse with image pixel (IMG_W-1, IMG_H-1)

Behaviour:
- Reset: all outputs are 0, the active mode is 1:1 and the delay pipeline is cleared. Reset is asynchronous assert and synchronous release.
- Mode latch: active_mode is loaded from scale_sel only on a clock where x_pixel==0 and y_pixel==0. A scale_sel change mid-frame therefore takes effect at the next frame.
- Image coordinates:
  - Mode 0: ix = x_pixel, iy = y_pixel.
  - Mode 1: ix = x_pixel>>1, iy = y_pixel>>1.
- Window: in_win = DE && ix < IMG_W && iy < IMG_H, with coordinates compared at full 10-bit width.
- addr is combinational: iy*IMG_W + ix, truncated to ADDR_W, when in_win; otherwise 0. It is never high-Z.
- Delay line: in_win, ix, iy, a first-visit flag and the ROI-hit flag are delayed by MEM_LAT clocks, then registered together with imgData in one output stage. Total latency is MEM_LAT+1 clocks from x_pixel/y_pixel to every output.
- First-visit flag:
  - Mode 0: equals in_win.
  - Mode 1: in_win && x_pixel[0]==0 && y_pixel[0]==0, so the detector sees each image pixel exactly once per frame.
- Stream outputs:
  - pixel_valid = delayed first-visit flag.
  - RGB888 = {R5,R5[4:2]}, {G6,G6[5:4]}, {B5,B5[4:2]}.
  - When pixel_valid is 0, pixel_r8/g8/b8 are 0; pixel_x/y hold their last value.
- VGA outputs:
  - Colour is the upper 4 bits of each RGB565 field when delayed in_win, otherwise 0.
  - If the delayed ROI-hit flag is set, ROI_COLOR overrides the image colour.
- ROI-hit condition: roi_en && in_win && roi_x0<=roi_x1 && roi_y0<=roi_y1 && ix in [roi_x0,roi_x1] && iy in [roi_y0,roi_y1] && (ix==roi_x0 || ix==roi_x1 || iy==roi_y0 || iy==roi_y1). An inverted rectangle draws nothing. The ROI never alters the stream.
- line_start = pixel_valid && pixel_x==0.
- frame_start = pixel_valid && pixel_x==0 && pixel_y==0.
- frame_end = pixel_valid && pixel_x==IMG_W-1 && pixel_y==IMG_H-1.
- Each of line_start, frame_start and frame_end is a single-cycle pulse coincident with its pixel.
- Reset asserted mid-frame clears all outputs immediately. After release, the block produces no frame_start until the next screen (0,0).

Test Plan:
- Mode 0, MEM_LAT=1, BRAM model returning addr[15:0] as data, full 640x480 scan -> addr at (5,2) is 645; outputs follow 2 clocks later; pixel_valid count per frame is 76800; one frame_start, one frame_end, 240 line_start.
- Mode 1, MEM_LAT=3 -> screen (7,9) yields addr 1283; 76800 valid pixels per frame with coordinates (0..319, 0..239); latency 4 clocks; VGA is non-black over the full 640x480.
- imgData=16'hF81F at (0,0) -> pixel_r8=FF, g8=00, b8=FF; r/g/b_port = F/0/F.
- ROI (10,10)-(20,15) with roi_en=1 -> ROI_COLOR at image (10,12) and (15,15), image colour at (15,12), stream data unchanged; swapping x0 and x1 -> no border drawn.
- Toggle scale_sel at screen y=100 -> the mode changes only at the next frame; the current frame completes with unchanged pixel_valid spacing.
- Assert reset_n=0 at screen (200,100) -> all outputs 0 asynchronously; after release, the first frame_start occurs exactly MEM_LAT+1 clocks after the next screen (0,0).
